sr_cmd_driver: RTL and testbench

Command sequencer that sits directly upstream of the SR flip-flop stage and generates its `s`/`r` inputs. It accepts set/clear/toggle requests through a valid/ready handshake and buffers them in a small FIFO. Each request becomes a clean `s` or `r` pulse that never asserts both lines together, so the illegal S=R=1 condition cannot occur. The block also keeps a shadow copy of the expected flip-flop state and checks it against the flip-flop's `q` output.

---
 rtl/sr_cmd_driver.sv | 161 ++++++++++++++++
 tb/tb_sr_cmd_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_driver.sv
// Set/clear/toggle command sequencer driving an SR flip-flop stage.
// Commands are queued, issued as non-overlapping s/r pulses and the flip-flop q is cross-checked.
module sr_cmd_driver #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    output logic       q_exp,
    output logic       busy,
    output logic       mismatch
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [1:0]          fifo_q [DEPTH];
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                s_q, s_d;
    logic                r_q, r_d;
    logic                q_exp_q, q_exp_d;
    logic                tgt_q, tgt_d;
    logic                mismatch_q, mismatch_d;
    logic                push;
    logic                pop;
    logic [1:0]          head;

    assign cmd_ready = (cnt_q < CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready && (cmd_op != OP_NOP);
    assign head      = fifo_q[rd_ptr_q];

    assign s        = s_q;
    assign r        = r_q;
    assign q_exp    = q_exp_q;
    assign mismatch = mismatch_q;
    assign busy     = (state_q != ST_IDLE) || (cnt_q != '0);

    // Sequencer: pop in IDLE, hold the pulse in DRIVE, check feedback in GAP
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        s_d        = s_q;
        r_d        = r_q;
        q_exp_d    = q_exp_q;
        tgt_d      = tgt_q;
        mismatch_d = mismatch_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_d = 1'b0;
                r_d = 1'b0;
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    state_d = ST_DRIVE;
                    case (head)
                        OP_SET: begin
                            s_d   = 1'b1;
                            tgt_d = 1'b1;
                        end
                        OP_CLR: begin
                            r_d   = 1'b1;
                            tgt_d = 1'b0;
                        end
                        OP_TGL: begin
                            s_d   = ~q_exp_q;
                            r_d   = q_exp_q;
                            tgt_d = ~q_exp_q;
                        end
                        default: tgt_d = q_exp_q;
                    endcase
                end
            end
            ST_DRIVE: begin
                if (hold_q == '0) begin
                    state_d = ST_GAP;
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    q_exp_d = tgt_q;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_GAP: begin
                s_d     = 1'b0;
                r_d     = 1'b0;
                state_d = ST_IDLE;
                if (q_fb != q_exp_q) mismatch_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
            end
        endcase
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hold_q     <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            q_exp_q    <= 1'b0;
            tgt_q      <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            hold_q     <= hold_d;
            s_q        <= s_d;
            r_q        <= r_d;
            q_exp_q    <= q_exp_d;
            tgt_q      <= tgt_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= OP_NOP;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= cmd_op;
        end
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Self-checking bench for sr_cmd_driver: vector table, pulse scoreboard and multi-cycle corner cases.
module tb_sr_cmd_driver;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] CLR = 2'b01;
    localparam logic [1:0] SET = 2'b10;
    localparam logic [1:0] TGL = 2'b11;
    localparam int DEPTH = 4;
    localparam int HOLD  = 1;

    logic clk = 1'b0;
    logic rst, cmd_valid, cmd_ready, s, r, q_fb, q_exp, busy, mismatch;
    logic [1:0] cmd_op;
    logic rst3, valid3, ready3, s3, r3, q_fb3, q_exp3, busy3, mismatch3;
    logic [1:0] op3;

    logic ff_q, force_q0;
    int   n_total = 0, n_pass = 0, cyc = 0;
    int   acc_cnt = 0, pulse_cnt = 0;
    logic m_q = 1'b0;
    logic chk_ready = 1'b0, stall_seen = 1'b0;
    logic [1:0] sb [$];
    int   starts [$];

    typedef struct {
        logic [1:0] op;
        logic       exp_s;
        logic       exp_r;
        logic       exp_q;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_cmd_driver #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .s(s), .r(r), .q_fb(q_fb), .q_exp(q_exp), .busy(busy), .mismatch(mismatch)
    );

    sr_cmd_driver #(.DEPTH(DEPTH), .HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .cmd_valid(valid3), .cmd_op(op3), .cmd_ready(ready3),
        .s(s3), .r(r3), .q_fb(q_fb3), .q_exp(q_exp3), .busy(busy3), .mismatch(mismatch3)
    );

    // SR flip-flop model downstream of the sequencer
    always @(posedge clk or negedge rst) begin
        if (!rst)   ff_q <= 1'b0;
        else if (s) ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end
    assign q_fb = force_q0 ? 1'b0 : ff_q;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected pulse for an enqueued command, resolved in queue order
    task automatic expect_cmd(input logic [1:0] op);
        acc_cnt++;
        case (op)
            SET: begin sb.push_back(2'b10); m_q = 1'b1; end
            CLR: begin sb.push_back(2'b01); m_q = 1'b0; end
            default: begin sb.push_back(m_q ? 2'b01 : 2'b10); m_q = ~m_q; end
        endcase
    endtask

    // Pulse monitor: pops the scoreboard at each pulse start, checks width and exclusivity
    logic [1:0] prev = 2'b00;
    int plen = 0;
    always @(negedge clk) begin
        logic [1:0] cur;
        logic [1:0] e;
        cur = {s, r};
        check(!(s && r), "s_and_r", 32'(cur), 32'(0));
        if (cur != 2'b00 && prev == 2'b00) begin
            pulse_cnt++;
            starts.push_back(cyc);
            plen = 1;
            if (sb.size() == 0) begin
                check(1'b0 || (cur == 2'b00), "unexpected_pulse", 32'(cur), 32'(0));
            end else begin
                e = sb.pop_front();
                check(cur == e, "pulse_kind", 32'(cur), 32'(e));
            end
        end else if (cur != 2'b00) begin
            plen++;
            check(cur == prev, "pulse_switch", 32'(cur), 32'(prev));
        end else if (prev != 2'b00) begin
            check(plen == HOLD, "pulse_width", 32'(plen), 32'(HOLD));
        end
        prev = cur;
    end

    // Present a command until accepted; optionally cross-check cmd_ready against occupancy
    task automatic send(input logic [1:0] op);
        bit done = 0;
        logic rdy;
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk); #1;
            rdy = cmd_ready;
            if (chk_ready) check(rdy == ((acc_cnt - pulse_cnt) < DEPTH), "cmd_ready", 32'(rdy), 32'((acc_cnt - pulse_cnt) < DEPTH));
            if (!rdy) stall_seen = 1'b1;
            @(posedge clk);
            if (rdy) begin
                done = 1;
                if (op != NOP) expect_cmd(op);
            end
        end
        if (!done) check(1'b0 || cmd_ready, "send_timeout", 32'(cmd_ready), 32'(1));
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
            if (!busy && sb.size() == 0) done = 1;
        end
        if (!done) check(1'b0 || !busy, "idle_timeout", 32'(busy), 32'(0));
    endtask

    initial begin
        logic [1:0] fill_ops [8];
        int base;
        logic pulse3;

        tbl[0] = '{SET, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{SET, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{CLR, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{TGL, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{TGL, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{NOP, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{TGL, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{CLR, 1'b0, 1'b1, 1'b0};
        fill_ops = '{SET, CLR, SET, CLR, CLR, SET, SET, CLR};

        rst = 1'b0; rst3 = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; force_q0 = 1'b0;
        valid3 = 1'b0; op3 = NOP; q_fb3 = 1'b0;

        // Reset state and idle
        repeat (3) @(posedge clk); #1;
        check({s, r, q_exp, mismatch, busy, cmd_ready} == 6'b000001, "reset_vals",
              32'({s, r, q_exp, mismatch, busy, cmd_ready}), 32'(6'b000001));
        @(negedge clk); rst = 1'b1; rst3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check({s, r, q_exp, cmd_ready, busy} == 5'b00010, "idle_vals",
                  32'({s, r, q_exp, cmd_ready, busy}), 32'(5'b00010));
        end

        // Vector table: one command at a time from idle, cycle-exact
        for (int i = 0; i < 8; i++) begin
            check(cmd_ready == 1'b1, "tbl_ready", 32'(cmd_ready), 32'(1));
            cmd_valid = 1'b1; cmd_op = tbl[i].op;
            if (tbl[i].op != NOP) expect_cmd(tbl[i].op);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            check(busy == (tbl[i].op != NOP), "tbl_busy_accept", 32'(busy), 32'(tbl[i].op != NOP));
            check({s, r} == 2'b00, "tbl_sr_accept", 32'({s, r}), 32'(0));
            @(posedge clk); #1;
            check({s, r} == {tbl[i].exp_s, tbl[i].exp_r}, "tbl_pulse", 32'({s, r}), 32'({tbl[i].exp_s, tbl[i].exp_r}));
            @(posedge clk); #1;
            check({s, r, q_exp} == {2'b00, tbl[i].exp_q}, "tbl_gap_qexp", 32'({s, r, q_exp}), 32'({2'b00, tbl[i].exp_q}));
            @(posedge clk); #1;
            check({busy, mismatch} == 2'b00, "tbl_done", 32'({busy, mismatch}), 32'(0));
        end

        // Fill and drain with back-to-back presentation
        base = starts.size();
        chk_ready = 1'b1; stall_seen = 1'b0;
        for (int i = 0; i < 8; i++) send(fill_ops[i]);
        chk_ready = 1'b0;
        wait_idle();
        check(stall_seen == 1'b1, "fill_stall", 32'(stall_seen), 32'(1));
        check(starts.size() == base + 8, "fill_pulses", 32'(starts.size() - base), 32'(8));
        if (starts.size() == base + 8)
            for (int i = 1; i < 8; i++)
                check(starts[base+i] - starts[base+i-1] == 3, "fill_spacing",
                      32'(starts[base+i] - starts[base+i-1]), 32'(3));
        check(q_exp == m_q, "fill_qexp", 32'(q_exp), 32'(m_q));

        // Mismatch detection and stickiness
        force_q0 = 1'b1;
        cmd_valid = 1'b1; cmd_op = SET; expect_cmd(SET);
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check(mismatch == 1'b0, "mm_before", 32'(mismatch), 32'(0));
        @(posedge clk); #1;
        check(mismatch == 1'b1, "mm_set", 32'(mismatch), 32'(1));
        force_q0 = 1'b0;
        send(CLR); send(SET);
        wait_idle();
        check(mismatch == 1'b1, "mm_sticky", 32'(mismatch), 32'(1));
        @(negedge clk); #2; rst = 1'b0; #1;
        check({mismatch, q_exp, busy, cmd_ready} == 4'b0001, "mm_reset",
              32'({mismatch, q_exp, busy, cmd_ready}), 32'(4'b0001));
        m_q = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Reset mid-DRIVE with HOLD_CYCLES=3 and two commands queued
        @(posedge clk); #1;
        valid3 = 1'b1; op3 = SET;
        @(posedge clk); #1; op3 = CLR;
        @(posedge clk); #1; op3 = SET;
        @(posedge clk); #1; valid3 = 1'b0;
        check({s3, r3, busy3} == 3'b101, "r3_drive", 32'({s3, r3, busy3}), 32'(3'b101));
        #2; rst3 = 1'b0; #1;
        check({s3, r3} == 2'b00, "r3_async_drop", 32'({s3, r3}), 32'(0));
        check({busy3, ready3, q_exp3} == 3'b010, "r3_reset_state", 32'({busy3, ready3, q_exp3}), 32'(3'b010));
        @(negedge clk); rst3 = 1'b1;
        pulse3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (s3 || r3 || busy3) pulse3 = 1'b1;
        end
        check(pulse3 == 1'b0, "r3_no_pulses", 32'(pulse3), 32'(0));
        check({busy3, q_exp3, ready3} == 3'b001, "r3_after", 32'({busy3, q_exp3, ready3}), 32'(3'b001));

        check(sb.size() == 0, "sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
